// File: rtl/aq_axil_pkg.sv
// Shared types for the AXI4-Lite single-outstanding initiator.
// Holds the controller state encoding and the AXI response codes.
package aq_axil_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_RSP     = 3'd5
  } state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/aq_axil_master.sv
// One-outstanding AXI4-Lite initiator: a command is turned into one AXI
// write or read, and the result is held on the response port until taken.
module aq_axil_master
  import aq_axil_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 1024,
  parameter logic [2:0] AXPROT         = 3'b000,
  parameter logic [3:0] AXCACHE        = 4'b0011
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic        CMD_WRITE,
  input  logic [31:0] CMD_ADDR,
  input  logic [31:0] CMD_WDATA,
  input  logic [3:0]  CMD_WSTRB,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [31:0] RSP_RDATA,
  output logic [1:0]  RSP_RESP,
  output logic        RSP_TIMEOUT,
  output logic [31:0] M_AXI_AWADDR,
  output logic [3:0]  M_AXI_AWCACHE,
  output logic [2:0]  M_AXI_AWPROT,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY,
  input  logic [1:0]  M_AXI_BRESP,
  output logic [31:0] M_AXI_ARADDR,
  output logic [3:0]  M_AXI_ARCACHE,
  output logic [2:0]  M_AXI_ARPROT,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  input  logic [31:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY
);

  localparam logic [31:0] TIMEOUT_LIMIT = 32'(TIMEOUT_CYCLES);

  state_t      state_reg, state_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [3:0]  wstrb_reg, wstrb_next;
  logic        awvalid_reg, awvalid_next;
  logic        wvalid_reg, wvalid_next;
  logic        bready_reg, bready_next;
  logic        arvalid_reg, arvalid_next;
  logic        rready_reg, rready_next;
  logic        rsp_valid_reg, rsp_valid_next;
  logic [31:0] rsp_rdata_reg, rsp_rdata_next;
  logic [1:0]  rsp_resp_reg, rsp_resp_next;
  logic        rsp_timeout_reg, rsp_timeout_next;
  logic [31:0] cnt_reg, cnt_next;
  logic [31:0] cnt_inc;
  logic        expire;
  logic        abort;
  logic        aw_done, w_done;

  assign cnt_inc = cnt_reg + 32'd1;
  // ">=" keeps the abort armed after a handshake won the race on the limit edge.
  assign expire  = (TIMEOUT_LIMIT != 32'd0) && (cnt_inc >= TIMEOUT_LIMIT);
  assign aw_done = !awvalid_reg || M_AXI_AWREADY;
  assign w_done  = !wvalid_reg || M_AXI_WREADY;

  always_comb begin
    state_next       = state_reg;
    addr_next        = addr_reg;
    wdata_next       = wdata_reg;
    wstrb_next       = wstrb_reg;
    awvalid_next     = awvalid_reg;
    wvalid_next      = wvalid_reg;
    bready_next      = bready_reg;
    arvalid_next     = arvalid_reg;
    rready_next      = rready_reg;
    rsp_valid_next   = rsp_valid_reg;
    rsp_rdata_next   = rsp_rdata_reg;
    rsp_resp_next    = rsp_resp_reg;
    rsp_timeout_next = rsp_timeout_reg;
    cnt_next         = cnt_reg;
    abort            = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (CMD_VALID) begin
          addr_next  = CMD_ADDR;
          wdata_next = CMD_WDATA;
          wstrb_next = CMD_WSTRB;
          cnt_next   = 32'd0;
          if (CMD_WRITE) begin
            state_next   = ST_WR;
            awvalid_next = 1'b1;
            wvalid_next  = 1'b1;
          end else begin
            state_next   = ST_RD_ADDR;
            arvalid_next = 1'b1;
          end
        end
      end
      ST_WR: begin
        cnt_next = cnt_inc;
        if (M_AXI_AWREADY) awvalid_next = 1'b0;
        if (M_AXI_WREADY)  wvalid_next  = 1'b0;
        if (aw_done && w_done) begin
          state_next  = ST_WR_RESP;
          bready_next = 1'b1;
        end else if (expire) begin
          abort = 1'b1;
        end
      end
      ST_WR_RESP: begin
        cnt_next = cnt_inc;
        if (M_AXI_BVALID) begin
          state_next       = ST_RSP;
          bready_next      = 1'b0;
          rsp_valid_next   = 1'b1;
          rsp_resp_next    = M_AXI_BRESP;
          rsp_rdata_next   = 32'd0;
          rsp_timeout_next = 1'b0;
        end else if (expire) begin
          abort = 1'b1;
        end
      end
      ST_RD_ADDR: begin
        cnt_next = cnt_inc;
        if (M_AXI_ARREADY) begin
          state_next   = ST_RD_DATA;
          arvalid_next = 1'b0;
          rready_next  = 1'b1;
        end else if (expire) begin
          abort = 1'b1;
        end
      end
      ST_RD_DATA: begin
        cnt_next = cnt_inc;
        if (M_AXI_RVALID) begin
          state_next       = ST_RSP;
          rready_next      = 1'b0;
          rsp_valid_next   = 1'b1;
          rsp_resp_next    = M_AXI_RRESP;
          rsp_rdata_next   = M_AXI_RDATA;
          rsp_timeout_next = 1'b0;
        end else if (expire) begin
          abort = 1'b1;
        end
      end
      ST_RSP: begin
        if (RSP_READY) begin
          state_next     = ST_IDLE;
          rsp_valid_next = 1'b0;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (abort) begin
      state_next       = ST_RSP;
      awvalid_next     = 1'b0;
      wvalid_next      = 1'b0;
      bready_next      = 1'b0;
      arvalid_next     = 1'b0;
      rready_next      = 1'b0;
      rsp_valid_next   = 1'b1;
      rsp_resp_next    = SLVERR;
      rsp_rdata_next   = 32'd0;
      rsp_timeout_next = 1'b1;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      addr_reg        <= 32'd0;
      wdata_reg       <= 32'd0;
      wstrb_reg       <= 4'd0;
      awvalid_reg     <= 1'b0;
      wvalid_reg      <= 1'b0;
      bready_reg      <= 1'b0;
      arvalid_reg     <= 1'b0;
      rready_reg      <= 1'b0;
      rsp_valid_reg   <= 1'b0;
      rsp_rdata_reg   <= 32'd0;
      rsp_resp_reg    <= 2'b00;
      rsp_timeout_reg <= 1'b0;
      cnt_reg         <= 32'd0;
    end else begin
      addr_reg        <= addr_next;
      wdata_reg       <= wdata_next;
      wstrb_reg       <= wstrb_next;
      awvalid_reg     <= awvalid_next;
      wvalid_reg      <= wvalid_next;
      bready_reg      <= bready_next;
      arvalid_reg     <= arvalid_next;
      rready_reg      <= rready_next;
      rsp_valid_reg   <= rsp_valid_next;
      rsp_rdata_reg   <= rsp_rdata_next;
      rsp_resp_reg    <= rsp_resp_next;
      rsp_timeout_reg <= rsp_timeout_next;
      cnt_reg         <= cnt_next;
    end
  end

  assign CMD_READY     = (state_reg == ST_IDLE);
  assign RSP_VALID     = rsp_valid_reg;
  assign RSP_RDATA     = rsp_rdata_reg;
  assign RSP_RESP      = rsp_resp_reg;
  assign RSP_TIMEOUT   = rsp_timeout_reg;
  assign M_AXI_AWADDR  = addr_reg;
  assign M_AXI_ARADDR  = addr_reg;
  assign M_AXI_AWCACHE = AXCACHE;
  assign M_AXI_ARCACHE = AXCACHE;
  assign M_AXI_AWPROT  = AXPROT;
  assign M_AXI_ARPROT  = AXPROT;
  assign M_AXI_AWVALID = awvalid_reg;
  assign M_AXI_WVALID  = wvalid_reg;
  assign M_AXI_WDATA   = wdata_reg;
  assign M_AXI_WSTRB   = wstrb_reg;
  assign M_AXI_BREADY  = bready_reg;
  assign M_AXI_ARVALID = arvalid_reg;
  assign M_AXI_RREADY  = rready_reg;

endmodule

// File: tb/tb_aq_axil_master.sv
// Directed bench for aq_axil_master: the bench scripts the AXI slave
// cycle by cycle and compares against hand-computed expectations.
module tb_aq_axil_master;
  import aq_axil_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        CMD_VALID, CMD_READY, CMD_WRITE;
  logic [31:0] CMD_ADDR, CMD_WDATA;
  logic [3:0]  CMD_WSTRB;
  logic        RSP_VALID, RSP_READY, RSP_TIMEOUT;
  logic [31:0] RSP_RDATA;
  logic [1:0]  RSP_RESP;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic [3:0]  AWCACHE, ARCACHE, WSTRB;
  logic [2:0]  AWPROT, ARPROT;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [1:0]  BRESP, RRESP;

  int vectors     = 0;
  int miscompares = 0;

  always #5 ACLK = ~ACLK;

  aq_axil_master #(.TIMEOUT_CYCLES(8)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
    .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA), .CMD_WSTRB(CMD_WSTRB),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA),
    .RSP_RESP(RSP_RESP), .RSP_TIMEOUT(RSP_TIMEOUT),
    .M_AXI_AWADDR(AWADDR), .M_AXI_AWCACHE(AWCACHE), .M_AXI_AWPROT(AWPROT),
    .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
    .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WVALID(WVALID),
    .M_AXI_WREADY(WREADY),
    .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY), .M_AXI_BRESP(BRESP),
    .M_AXI_ARADDR(ARADDR), .M_AXI_ARCACHE(ARCACHE), .M_AXI_ARPROT(ARPROT),
    .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
    .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID),
    .M_AXI_RREADY(RREADY)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled and inputs driven 1ns after the edge.
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb);
    CMD_VALID = 1'b1; CMD_WRITE = wr; CMD_ADDR = addr; CMD_WDATA = data; CMD_WSTRB = strb;
    tick();
    CMD_VALID = 1'b0; CMD_ADDR = 32'h0; CMD_WDATA = 32'h0; CMD_WSTRB = 4'h0;
  endtask

  task automatic slave_idle();
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 2'b00;
    ARREADY = 0; RVALID = 0; RDATA = 32'h0; RRESP = 2'b00;
  endtask

  initial begin
    int n;
    logic any_rsp;
    ARESET = 1'b1; CMD_VALID = 0; CMD_WRITE = 0; CMD_ADDR = 0; CMD_WDATA = 0; CMD_WSTRB = 0;
    RSP_READY = 1'b1;
    slave_idle();
    repeat (3) tick();
    ARESET = 1'b0;
    tick();
    chk("rst_cmd_ready", 32'(CMD_READY), 32'd1);
    chk("rst_valids", {27'd0, AWVALID, WVALID, ARVALID, BREADY, RREADY}, 32'd0);
    chk("rst_rsp", {28'd0, RSP_VALID, RSP_RESP, RSP_TIMEOUT}, 32'd0);
    chk("rst_rsp_rdata", RSP_RDATA, 32'd0);
    chk("rst_awaddr", AWADDR, 32'd0);
    chk("rst_wdata", WDATA, 32'd0);
    chk("rst_wstrb", 32'(WSTRB), 32'd0);
    chk("cache_prot", {21'd0, AWCACHE, AWPROT, ARCACHE}, {21'd0, 4'b0011, 3'b000, 4'b0011});
    $display("txn reset: checked idle state");

    // Zero-wait write: AW/W one cycle, BREADY one cycle, response in cycle 3.
    AWREADY = 1; WREADY = 1;
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    chk("w0_aw_w_valid", {30'd0, AWVALID, WVALID}, 32'd3);
    chk("w0_cmd_ready", 32'(CMD_READY), 32'd0);
    chk("w0_awaddr", AWADDR, 32'h10);
    chk("w0_wdata", WDATA, 32'hDEADBEEF);
    chk("w0_wstrb", 32'(WSTRB), 32'hF);
    tick();
    AWREADY = 0; WREADY = 0;
    chk("w0_after_hs", {29'd0, AWVALID, WVALID, BREADY}, 32'd1);
    chk("w0_rsp_early", 32'(RSP_VALID), 32'd0);
    BVALID = 1; BRESP = OKAY;
    tick();
    BVALID = 0;
    chk("w0_bready_drop", 32'(BREADY), 32'd0);
    chk("w0_rsp", {28'd0, RSP_VALID, RSP_RESP, RSP_TIMEOUT}, {28'd0, 1'b1, OKAY, 1'b0});
    chk("w0_rsp_rdata", RSP_RDATA, 32'd0);
    tick();
    chk("w0_back_idle", {30'd0, RSP_VALID, CMD_READY}, 32'd1);
    $display("txn write 0x10=0xDEADBEEF zero-wait: done");

    // Write with WREADY four cycles after the AW handshake.
    AWREADY = 1; WREADY = 0;
    issue(1'b1, 32'h44, 32'hA5A5_0F0F, 4'h3);
    tick();
    AWREADY = 0;
    chk("w1_aw_drop", {30'd0, AWVALID, WVALID}, 32'd1);
    n = 0;
    repeat (3) begin
      tick();
      if (WVALID && !AWVALID && !BREADY) n++;
    end
    chk("w1_w_held", 32'(n), 32'd3);
    chk("w1_wdata_stable", WDATA, 32'hA5A5_0F0F);
    WREADY = 1;
    tick();
    WREADY = 0;
    chk("w1_w_drop", {30'd0, WVALID, BREADY}, 32'd1);
    BVALID = 1; BRESP = EXOKAY;
    tick();
    BVALID = 0;
    chk("w1_rsp", {28'd0, RSP_VALID, RSP_RESP, RSP_TIMEOUT}, {28'd0, 1'b1, EXOKAY, 1'b0});
    tick();
    any_rsp = 1'b0;
    repeat (4) begin
      tick();
      any_rsp |= RSP_VALID;
    end
    chk("w1_single_rsp", 32'(any_rsp), 32'd0);
    $display("txn write 0x44 late WREADY: done");

    // Read with two wait cycles on R; then hold RSP_READY low for five cycles.
    ARREADY = 1;
    issue(1'b0, 32'h20, 32'h0, 4'h0);
    chk("r0_arvalid", 32'(ARVALID), 32'd1);
    chk("r0_araddr", ARADDR, 32'h20);
    tick();
    ARREADY = 0;
    chk("r0_ar_drop", {30'd0, ARVALID, RREADY}, 32'd1);
    repeat (2) tick();
    chk("r0_wait", {30'd0, RREADY, RSP_VALID}, 32'd2);
    RSP_READY = 0;
    RVALID = 1; RDATA = 32'h12345678; RRESP = SLVERR;
    tick();
    RVALID = 0; RDATA = 32'hFFFF_FFFF; RRESP = 2'b00;
    chk("r0_rready_drop", 32'(RREADY), 32'd0);
    chk("r0_rdata", RSP_RDATA, 32'h12345678);
    chk("r0_rsp", {28'd0, RSP_VALID, RSP_RESP, RSP_TIMEOUT}, {28'd0, 1'b1, SLVERR, 1'b0});
    CMD_VALID = 1; CMD_WRITE = 1; CMD_ADDR = 32'h99;
    n = 0;
    repeat (5) begin
      tick();
      if (RSP_VALID && !CMD_READY && RSP_RDATA == 32'h12345678 && RSP_RESP == SLVERR &&
          !RSP_TIMEOUT && !AWVALID && !ARVALID) n++;
    end
    chk("r0_hold_stable", 32'(n), 32'd5);
    CMD_VALID = 0; CMD_WRITE = 0; CMD_ADDR = 0;
    RSP_READY = 1;
    tick();
    chk("r0_release", {30'd0, RSP_VALID, CMD_READY}, 32'd1);
    $display("txn read 0x20 -> 0x12345678/SLVERR with held response: done");

    // Timeout: ARREADY never asserted with an 8-cycle limit.
    issue(1'b0, 32'h30, 32'h0, 4'h0);
    n = 0;
    while (ARVALID && n < 20) begin
      n++;
      tick();
    end
    chk("to_ar_cycles", 32'(n), 32'd8);
    chk("to_rsp", {28'd0, RSP_VALID, RSP_RESP, RSP_TIMEOUT}, {28'd0, 1'b1, SLVERR, 1'b1});
    chk("to_rdata", RSP_RDATA, 32'd0);
    chk("to_readies", {30'd0, RREADY, ARVALID}, 32'd0);
    tick();
    $display("txn read 0x30 timeout: done");

    // AR handshake on the limit edge wins; the R phase then times out.
    issue(1'b0, 32'h34, 32'h0, 4'h0);
    repeat (7) tick();
    ARREADY = 1;
    tick();
    ARREADY = 0;
    chk("pri_rd_data", {29'd0, ARVALID, RREADY, RSP_VALID}, 32'd2);
    tick();
    chk("pri_timeout", {28'd0, RSP_VALID, RSP_RESP, RSP_TIMEOUT}, {28'd0, 1'b1, SLVERR, 1'b1});
    tick();
    $display("txn read 0x34 handshake on limit edge: done");

    // Reset pulsed in WR_RESP abandons the write.
    AWREADY = 1; WREADY = 1;
    issue(1'b1, 32'h50, 32'h1111_2222, 4'hF);
    tick();
    AWREADY = 0; WREADY = 0;
    chk("rstmid_bready", 32'(BREADY), 32'd1);
    #2 ARESET = 1'b1;
    #1;
    chk("rstmid_outs", {27'd0, AWVALID, WVALID, ARVALID, BREADY, RREADY}, 32'd0);
    chk("rstmid_addr", AWADDR | WDATA, 32'd0);
    BVALID = 1; BRESP = OKAY;
    tick();
    ARESET = 1'b0;
    any_rsp = 1'b0;
    repeat (3) begin
      tick();
      any_rsp |= RSP_VALID;
    end
    BVALID = 0;
    chk("rstmid_no_rsp", 32'(any_rsp), 32'd0);
    chk("rstmid_cmd_ready", 32'(CMD_READY), 32'd1);
    $display("txn write 0x50 reset during WR_RESP: done");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
